axi_burst_strobe_gen: RTL

Parametrised AXI write-burst address and strobe sequencer for the accelerator's AXI slave write path. Accepts one AW-style burst command (address, length, size, burst type) and emits one beat descriptor per W beat: beat address, per-lane write strobe and last flag. It supports INCR, FIXED and WRAP bursts, unaligned start addresses and any data width. Illegal commands are flagged on ERR.

---
 rtl/axi_burst_strobe_gen.sv | 115 +++++++++++
 1 files changed

// File: rtl/axi_burst_strobe_gen.sv
// axi_burst_strobe_gen: AXI write-burst sequencer producing one address/strobe/last
// descriptor per W beat for FIXED, INCR and WRAP bursts, rejecting illegal commands.
module axi_burst_strobe_gen #(
    parameter int DATA_BYTES = 64,
    parameter int ADDR_W     = 64
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    input  logic                  CMD_VALID,
    output logic                  CMD_READY,
    input  logic [ADDR_W-1:0]     CMD_ADDR,
    input  logic [7:0]            CMD_LEN,
    input  logic [2:0]            CMD_SIZE,
    input  logic [1:0]            CMD_BURST,
    output logic                  BEAT_VALID,
    input  logic                  BEAT_READY,
    output logic [ADDR_W-1:0]     BEAT_ADDR,
    output logic [DATA_BYTES-1:0] BEAT_STRB,
    output logic [7:0]            BEAT_IDX,
    output logic                  BEAT_LAST,
    output logic                  ERR
);
    localparam int LB = $clog2(DATA_BYTES);
    typedef enum logic {IDLE, BURST} state_t;
    state_t                state_q;
    logic                  cmd_ready_q, beat_valid_q, beat_last_q, err_q;
    logic [ADDR_W-1:0]     beat_addr_q, wrap_mask_q;
    logic [DATA_BYTES-1:0] beat_strb_q;
    logic [7:0]            beat_idx_q, len_q;
    logic [2:0]            size_q;
    logic [1:0]            burst_q;
    logic [ADDR_W-1:0]     cmd_n, cmd_a0, cur_n, nxt_addr, wrap_mask_d;
    logic [DATA_BYTES-1:0] ones_cmd, ones_cur, strb0, nxt_strb;
    logic [16:0]           incr_end;
    logic                  illegal;

    always_comb begin
        cmd_n       = ADDR_W'(1) << CMD_SIZE;
        cmd_a0      = CMD_ADDR & ~(cmd_n - ADDR_W'(1));
        ones_cmd    = ~({DATA_BYTES{1'b1}} << cmd_n);
        // Leading lanes below an unaligned start address are dropped
        strb0       = (ones_cmd << cmd_a0[LB-1:0]) & ({DATA_BYTES{1'b1}} << CMD_ADDR[LB-1:0]);
        incr_end    = {5'd0, cmd_a0[11:0]} + ((17'(CMD_LEN) + 17'd1) << CMD_SIZE);
        wrap_mask_d = ((ADDR_W'(CMD_LEN) + ADDR_W'(1)) << CMD_SIZE) - ADDR_W'(1);
        illegal     = (32'(CMD_SIZE) > LB) || (CMD_BURST == 2'd3)
                   || (CMD_BURST == 2'd2 && (!(CMD_LEN inside {8'd1, 8'd3, 8'd7, 8'd15})
                                             || (CMD_ADDR & (cmd_n - ADDR_W'(1))) != '0))
                   || (CMD_BURST == 2'd1 && incr_end > 17'd4096);
        cur_n       = ADDR_W'(1) << size_q;
        ones_cur    = ~({DATA_BYTES{1'b1}} << cur_n);
        nxt_addr    = burst_q == 2'd0 ? beat_addr_q
                    : burst_q == 2'd2 ? (beat_addr_q & ~wrap_mask_q) | ((beat_addr_q + cur_n) & wrap_mask_q)
                    : (beat_addr_q & ~(cur_n - ADDR_W'(1))) + cur_n;
        nxt_strb    = burst_q == 2'd0 ? beat_strb_q : ones_cur << nxt_addr[LB-1:0];
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q      <= IDLE;
            cmd_ready_q  <= 1'b0;
            beat_valid_q <= 1'b0;
            beat_last_q  <= 1'b0;
            err_q        <= 1'b0;
            beat_addr_q  <= '0;
            beat_strb_q  <= '0;
            beat_idx_q   <= '0;
            wrap_mask_q  <= '0;
            len_q        <= '0;
            size_q       <= '0;
            burst_q      <= '0;
        end else begin
            err_q <= 1'b0;
            if (state_q == IDLE) begin
                cmd_ready_q <= 1'b1;
                if (CMD_VALID && cmd_ready_q) begin
                    if (illegal) begin
                        err_q <= 1'b1;
                    end else begin
                        state_q      <= BURST;
                        cmd_ready_q  <= 1'b0;
                        beat_valid_q <= 1'b1;
                        beat_addr_q  <= CMD_ADDR;
                        beat_strb_q  <= strb0;
                        beat_idx_q   <= 8'd0;
                        beat_last_q  <= CMD_LEN == 8'd0;
                        wrap_mask_q  <= wrap_mask_d;
                        len_q        <= CMD_LEN;
                        size_q       <= CMD_SIZE;
                        burst_q      <= CMD_BURST;
                    end
                end
            end else if (BEAT_READY) begin
                if (beat_last_q) begin
                    state_q      <= IDLE;
                    beat_valid_q <= 1'b0;
                    beat_last_q  <= 1'b0;
                    cmd_ready_q  <= 1'b1;
                end else begin
                    beat_addr_q <= nxt_addr;
                    beat_strb_q <= nxt_strb;
                    beat_idx_q  <= beat_idx_q + 8'd1;
                    beat_last_q <= beat_idx_q + 8'd1 == len_q;
                end
            end
        end
    end

    assign CMD_READY  = cmd_ready_q;
    assign BEAT_VALID = beat_valid_q;
    assign BEAT_ADDR  = beat_addr_q;
    assign BEAT_STRB  = beat_strb_q;
    assign BEAT_IDX   = beat_idx_q;
    assign BEAT_LAST  = beat_last_q;
    assign ERR        = err_q;
endmodule
